// File: rtl/decstage_pipe.sv
// rtl/decstage_pipe.sv - pipelined decode stage: RF, immediate gen, ID/EX register, optional load-use stall (DECSTAGE_LOADUSE_EN)
module decstage_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned R0_ZERO = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [31:0]       Instr,
  input  logic              Flush,
  input  logic              WB_WrEn,
  input  logic [4:0]        WB_Addr,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [5:0]        Out_Opcode,
  output logic [DATA_W-1:0] Out_Immed,
  output logic [DATA_W-1:0] Out_RF_A,
  output logic [DATA_W-1:0] Out_RF_B,
  output logic [4:0]        Out_Rd,
  output logic              Out_IsLoad,
  output logic              Stall
);

  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        b_addr;
  logic [4:0]        rd;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] sext16;
  logic [DATA_W-1:0] zext16;
  logic [DATA_W-1:0] immed;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] rf_b_out;
  logic              is_load;
  logic              wr_ok;
  logic              accept;

  // Register file storage; entries at or above NREGS are never written
  logic [DATA_W-1:0] rf [32];

  assign opcode = Instr[31:26];
  assign rs     = Instr[25:21];
  assign rd     = Instr[20:16];
  assign imm16  = Instr[15:0];
  assign sext16 = {{(DATA_W-16){imm16[15]}}, imm16};
  assign zext16 = {{(DATA_W-16){1'b0}}, imm16};

  // Store-type and branch opcodes read rt from [20:16], everything else from [15:11]
  always_comb begin
    b_addr = Instr[15:11];
    case (opcode)
      6'b000111, 6'b011111, 6'b000000, 6'b000001: b_addr = Instr[20:16];
      default: ;
    endcase
  end

  // Immediate generation by opcode class
  always_comb begin
    immed = zext16;
    case (opcode)
      6'b111000, 6'b110000, 6'b000011,
      6'b000111, 6'b001111, 6'b011111: immed = sext16;
      6'b110010, 6'b110011:            immed = zext16;
      6'b111111, 6'b000000, 6'b000001: immed = sext16 << 2;
      default:                         immed = zext16;
    endcase
  end

  assign is_load = (opcode == 6'b000011) | (opcode == 6'b001111);

  // Writes to nonexistent registers or to a hardwired-zero r0 are dropped
  assign wr_ok = WB_WrEn & (32'(WB_Addr) < NREGS) & ~((R0_ZERO != 0) & (WB_Addr == 5'd0));

  // Register file write port; cleared on reset
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wr_ok) begin
      rf[WB_Addr] <= WB_Data;
    end
  end

  // Read port A with write-first bypass; r0 and out-of-range reads give zero
  always_comb begin
    rd_a = '0;
    if ((32'(rs) < NREGS) && !((R0_ZERO != 0) && (rs == 5'd0))) begin
      if (WB_WrEn && (WB_Addr == rs)) rd_a = WB_Data;
      else                            rd_a = rf[rs];
    end
  end

  // Read port B with the same bypass and zero rules
  always_comb begin
    rd_b = '0;
    if ((32'(b_addr) < NREGS) && !((R0_ZERO != 0) && (b_addr == 5'd0))) begin
      if (WB_WrEn && (WB_Addr == b_addr)) rd_b = WB_Data;
      else                                rd_b = rf[b_addr];
    end
  end

  // Byte store keeps only the low byte of the store data
  always_comb begin
    rf_b_out = rd_b;
    if (opcode == 6'b000111) rf_b_out = {{(DATA_W-8){1'b0}}, rd_b[7:0]};
  end

`ifdef DECSTAGE_LOADUSE_EN
  assign Stall = In_valid & Out_valid & Out_IsLoad & (Out_Rd != 5'd0) &
                 ((Out_Rd == rs) | (Out_Rd == b_addr));
`else
  assign Stall = 1'b0;
`endif

  assign In_ready = (~Out_valid | Out_ready) & ~Stall;
  assign accept   = In_valid & In_ready & ~Flush;

  // ID/EX register: flush beats accept, drain empties it, otherwise hold
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Out_valid  <= 1'b0;
      Out_Opcode <= '0;
      Out_Immed  <= '0;
      Out_RF_A   <= '0;
      Out_RF_B   <= '0;
      Out_Rd     <= '0;
      Out_IsLoad <= 1'b0;
    end else if (Flush) begin
      Out_valid <= 1'b0;
    end else if (accept) begin
      Out_valid  <= 1'b1;
      Out_Opcode <= opcode;
      Out_Immed  <= immed;
      Out_RF_A   <= rd_a;
      Out_RF_B   <= rf_b_out;
      Out_Rd     <= rd;
      Out_IsLoad <= is_load;
    end else if (Out_ready) begin
      Out_valid <= 1'b0;
    end
  end

endmodule
